fp_round_stage: RTL and testbench
=================================

// Module: fp_round_stage
// PURPOSE
//  Pipelined rounding/packing stage downstream of the FP arithmetic units (sqrt, div, add, mul).
//  Consumes one uround_res_t plus a rounding mode per transaction and applies IEEE-754 rounding.
//  Produces the final packed result and RISC-V fflags {NV,DZ,OF,UF,NX}.
//  Valid/ready on both sides, 2-stage pipeline, full throughput, lossless under backpressure.
// PARAMETERS
//  FP_FORMAT  FP32  fp_format_e; sets FP_WIDTH/EXP_WIDTH/MANT_WIDTH through fp_pkg helpers
// PORTS
//  clk_i        in   1         clock; all state updates on rising edge
//  reset_i      in   1         asynchronous, active-low reset
//  in_valid_i   in   1         upstream transaction valid
//  in_ready_o   out  1         stage can accept; transfer = in_valid_i & in_ready_o
//  urnd_i       in   uround_res_t  {u_result, rs[1:0]={round,sticky}, round_en, invalid, exp_cout[1:0]}
//  rnd_i        in   roundmode_e   RNE=000 RTZ=001 RDN=010 RUP=011 RMM=100; sampled with urnd_i
//  out_valid_o  out  1         result valid
//  out_ready_i  in   1         downstream accepts; transfer = out_valid_o & out_ready_i
//  result_o     out  FP_WIDTH  rounded packed result
//  fflags_o     out  5         {NV,DZ,OF,UF,NX}
// BEHAVIOUR
//  Reset (reset_i=0, async): s1_valid=s2_valid=0, out_valid_o=0, result_o=0, fflags_o=0, in_ready_o=1;
//   in-flight transactions dropped, no partial output after reset release.
//  Flow: s2_adv = ~s2_valid | out_ready_i; s1_adv = ~s1_valid | s2_adv; in_ready_o = s1_adv.
//  Latency: 2 cycles from input transfer to out_valid_o with no stall; 1 transfer/cycle sustained.
//  Stage 1 (registered on input transfer): LSB=u_result.mant[0], R=rs[1], S=rs[0], sign=u_result.sign;
//   inc: RNE R&(S|LSB); RTZ 0; RDN sign&(R|S); RUP ~sign&(R|S); RMM R; reserved rnd codes behave as RNE.
//   inc forced 0 when round_en=0. sum = {exp,mant} + inc (EXP_WIDTH+MANT_WIDTH+1 bits; mant carry bumps exp).
//  Stage 2 (registered on s2_adv):
//   round_en=0: result_o = u_result unchanged; fflags = {invalid,0,0,0,0}.
//   round_en=1: ovf = exp_cout[1] | (sum exp field == all ones) | sum carry-out;
//    ovf: RNE/RMM -> +/-INF; RTZ -> +/-max finite; RDN -> -INF if sign else +max; RUP -> +INF if ~sign else -max.
//    else result_o = {sign, sum[EXP_WIDTH+MANT_WIDTH-1:0]}.
//    NX = R|S|ovf; OF = ovf; UF = (exp_cout[0] | pre-round exp==0) & NX & ~ovf (tininess before rounding);
//    NV = invalid; DZ = 0 always.
//  out_valid_o/result_o/fflags_o held stable while out_valid_o & ~out_ready_i.
//  Simultaneous in/out transfer with both stages full: both advance same cycle, no bubble, no loss.
//  Order strictly FIFO; no transaction dropped or duplicated except by reset.
// CONFIGURATION
//  FP_ROUND_SKID_EN defined: 1-entry skid buffer at input; in_ready_o driven from a flop
//   (= skid empty), no combinational out_ready_i->in_ready_o path; capacity 3, latency unchanged when unstalled.
//  Undefined: no skid; in_ready_o combinational from out_ready_i as above; capacity 2.
// TESTING
//  FP32 u_result=0x3F7FFFFF rs=2'b10 RNE round_en=1 -> 0x3F800000, fflags=5'b00001, out 2 cycles later.
//  0x3F800000 rs=10 RNE -> 0x3F800000 NX; 0x3F800001 rs=10 RNE -> 0x3F800002 NX; RMM on first -> 0x3F800001.
//  0x7F7FFFFF rs=11: RNE -> 0x7F800000 fflags=00101; RTZ -> 0x7F7FFFFF 00101; sign=1 RUP -> 0xFF7FFFFF.
//  round_en=0 u_result=0x7FC00000 invalid=1 rs=11 -> 0x7FC00000 fflags=10000.
//  4 back-to-back inputs, out_ready_i=0 for 5 cycles: in_ready_o low after 2 (3 with skid) accepts; all 4 in order.
//  reset_i low with both stages full: out_valid_o=0 immediately, in_ready_o=1; no stale result after release.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point types for the rounding/packing stage.
//  - fp_format_e and width helpers (exp_width / mant_width / fp_width)
//  - fp_t: packed {sign, exp, mant} laid out for FP_FMT
//  - uround_res_t: unrounded result bundle produced by the FP arithmetic units
//  - roundmode_e: RISC-V rounding-mode encoding
package fp_pkg;

  typedef enum logic [1:0] {
    FP16 = 2'd0,
    FP32 = 2'd1,
    FP64 = 2'd2
  } fp_format_e;

  function automatic int exp_width(fp_format_e fmt);
    case (fmt)
      FP16:    return 5;
      FP64:    return 11;
      default: return 8;
    endcase
  endfunction

  function automatic int mant_width(fp_format_e fmt);
    case (fmt)
      FP16:    return 10;
      FP64:    return 52;
      default: return 23;
    endcase
  endfunction

  function automatic int fp_width(fp_format_e fmt);
    return 1 + exp_width(fmt) + mant_width(fmt);
  endfunction

  // Format the uround_res_t bundle is laid out for; the stage's FP_FORMAT
  // parameter must match it.
  localparam fp_format_e FP_FMT = FP32;
  localparam int         EXP_W  = exp_width(FP_FMT);
  localparam int         MANT_W = mant_width(FP_FMT);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_t;

  typedef struct packed {
    fp_t        u_result;  // truncated result, already normalised
    logic [1:0] rs;        // {round, sticky}
    logic       round_en;  // 0: pass u_result through untouched
    logic       invalid;   // NV raised by the arithmetic unit
    logic [1:0] exp_cout;  // [1]: exponent overflow, [0]: tiny before rounding
  } uround_res_t;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } roundmode_e;

endpackage

// File: rtl/fp_round_stage.sv
// fp_round_stage: two-stage pipelined IEEE-754 rounding/packing stage.
//  Stage 1 decides the rounding increment and adds it to {exp, mant}.
//  Stage 2 resolves overflow per rounding mode and builds the fflags.
//  Valid/ready on both sides, one transfer per cycle, lossless under stall.
//
// Ports
//  clk_i        in   rising-edge clock
//  reset_i      in   asynchronous active-low reset
//  in_valid_i   in   upstream transaction valid
//  in_ready_o   out  stage can accept (transfer = in_valid_i & in_ready_o)
//  urnd_i       in   unrounded result bundle (fp_pkg::uround_res_t)
//  rnd_i        in   rounding mode, sampled with urnd_i; reserved codes act as RNE
//  out_valid_o  out  result valid
//  out_ready_i  in   downstream accepts (transfer = out_valid_o & out_ready_i)
//  result_o     out  rounded packed result
//  fflags_o     out  {NV, DZ, OF, UF, NX}
//
// Configuration macro FP_ROUND_SKID_EN:
//  defined   - one-entry skid buffer in front of stage 1; in_ready_o comes
//              straight from a flop, capacity 3.
//  undefined - in_ready_o is combinational from out_ready_i, capacity 2.
module fp_round_stage
  import fp_pkg::*;
#(
  parameter fp_format_e FP_FORMAT  = FP_FMT,
  localparam int        EXP_WIDTH  = exp_width(FP_FORMAT),
  localparam int        MANT_WIDTH = mant_width(FP_FORMAT),
  localparam int        FP_WIDTH   = fp_width(FP_FORMAT)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  uround_res_t         urnd_i,
  input  roundmode_e          rnd_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [FP_WIDTH-1:0] result_o,
  output logic [4:0]          fflags_o
);

  localparam int SUM_W = EXP_WIDTH + MANT_WIDTH + 1;

  typedef struct packed {
    uround_res_t urnd;
    roundmode_e  rnd;
  } in_t;

  typedef struct packed {
    logic [FP_WIDTH-1:0] raw;          // untouched u_result for the bypass path
    logic [SUM_W-1:0]    sum;          // {carry, exp, mant} after increment
    logic                r;
    logic                s;
    logic                round_en;
    logic                invalid;
    logic [1:0]          exp_cout;
    roundmode_e          mode;         // already normalised (reserved -> RNE)
    logic                pre_exp_zero;
  } s1_t;

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;
  in_t  src;
  logic src_valid;
  s1_t  s1_d;
  s1_t  s1_q;

  assign s2_adv      = ~s2_valid | out_ready_i;
  assign s1_adv      = ~s1_valid | s2_adv;
  assign out_valid_o = s2_valid;

  // ---------------------------------------------------------------------------
  // Input side: stage 1 is fed either directly or from the skid entry
  // ---------------------------------------------------------------------------
`ifdef FP_ROUND_SKID_EN
  logic skid_valid;
  logic skid_valid_d;
  logic in_ready_q;
  logic skid_push;
  logic skid_pop;
  in_t  skid_q;

  // An accepted beat parks in the skid entry only when stage 1 cannot take it.
  assign skid_push    = in_valid_i & in_ready_q & ~s1_adv;
  assign skid_pop     = skid_valid & s1_adv;
  assign skid_valid_d = skid_push | (skid_valid & ~skid_pop);

  // The skid entry is older than anything on the input, so it has priority.
  assign src       = skid_valid ? skid_q : in_t'{urnd: urnd_i, rnd: rnd_i};
  assign src_valid = skid_valid | (in_valid_i & in_ready_q);
  assign in_ready_o = in_ready_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      skid_valid <= skid_valid_d;
      in_ready_q <= ~skid_valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (skid_push) skid_q <= in_t'{urnd: urnd_i, rnd: rnd_i};
  end
`else
  assign src        = in_t'{urnd: urnd_i, rnd: rnd_i};
  assign src_valid  = in_valid_i;
  assign in_ready_o = s1_adv;
`endif

  // ---------------------------------------------------------------------------
  // Stage 1: rounding increment and add
  // ---------------------------------------------------------------------------
  logic inc;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    s1_d          = '0;
    inc           = 1'b0;
    s1_d.raw      = src.urnd.u_result;
    s1_d.r        = src.urnd.rs[1];
    s1_d.s        = src.urnd.rs[0];
    s1_d.round_en = src.urnd.round_en;
    s1_d.invalid  = src.urnd.invalid;
    s1_d.exp_cout = src.urnd.exp_cout;
    s1_d.pre_exp_zero = (src.urnd.u_result.exp == '0);

    case (src.rnd)
      RTZ, RDN, RUP, RMM: s1_d.mode = src.rnd;
      default:            s1_d.mode = RNE;
    endcase

    case (s1_d.mode)
      RTZ:     inc = 1'b0;
      RDN:     inc = src.urnd.u_result.sign & (s1_d.r | s1_d.s);
      RUP:     inc = ~src.urnd.u_result.sign & (s1_d.r | s1_d.s);
      RMM:     inc = s1_d.r;
      default: inc = s1_d.r & (s1_d.s | src.urnd.u_result.mant[0]);
    endcase
    if (!src.urnd.round_en) inc = 1'b0;

    // A mantissa carry ripples into the exponent, which is exactly the
    // renormalisation needed for 1.111..1 + ulp.
    s1_d.sum = {1'b0, src.urnd.u_result.exp, src.urnd.u_result.mant}
             + SUM_W'(inc);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) s1_valid <= 1'b0;
    else if (s1_adv) s1_valid <= src_valid;
  end

  // NOTE: pipeline payload registers carry no reset; only the valid bits
  // decide whether their contents are ever observed.
  always_ff @(posedge clk_i) begin
    if (s1_adv && src_valid) s1_q <= s1_d;
  end

  // ---------------------------------------------------------------------------
  // Stage 2: overflow resolution, packing, flags
  // ---------------------------------------------------------------------------
  logic                sign;
  logic                ovf;
  logic                nx;
  logic                uf;
  logic [FP_WIDTH-1:0] inf_val;
  logic [FP_WIDTH-1:0] max_val;
  logic [FP_WIDTH-1:0] res_d;
  logic [4:0]          flags_d;

  always_comb begin
    sign    = s1_q.raw[FP_WIDTH-1];
    ovf     = s1_q.exp_cout[1] | (&s1_q.sum[SUM_W-2:MANT_WIDTH]) | s1_q.sum[SUM_W-1];
    inf_val = {sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    max_val = {sign, {(EXP_WIDTH-1){1'b1}}, 1'b0, {MANT_WIDTH{1'b1}}};
    nx      = 1'b0;
    uf      = 1'b0;
    res_d   = s1_q.raw;
    flags_d = {s1_q.invalid, 4'b0000};

    if (s1_q.round_en) begin
      if (ovf) begin
        // Directed modes saturate toward zero on the side they round away from.
        case (s1_q.mode)
          RTZ:     res_d = max_val;
          RDN:     res_d = sign ? inf_val : max_val;
          RUP:     res_d = sign ? max_val : inf_val;
          default: res_d = inf_val;
        endcase
        flags_d = {s1_q.invalid, 1'b0, 1'b1, 1'b0, 1'b1};
      end else begin
        res_d   = {sign, s1_q.sum[SUM_W-2:0]};
        nx      = s1_q.r | s1_q.s;
        // Tininess is judged before rounding, so a subnormal that rounds up
        // into the normal range still reports underflow when inexact.
        uf      = (s1_q.exp_cout[0] | s1_q.pre_exp_zero) & nx;
        flags_d = {s1_q.invalid, 1'b0, 1'b0, uf, nx};
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      s2_valid <= 1'b0;
      result_o <= '0;
      fflags_o <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result_o <= res_d;
        fflags_o <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_round_stage.sv
// tb_fp_round_stage: directed vectors into a scoreboard queue; an independent
// monitor pops and compares each output beat, and checks that outputs hold
// steady while stalled.
module tb_fp_round_stage;
  import fp_pkg::*;

`ifdef FP_ROUND_SKID_EN
  localparam int STALL_ACCEPTS = 3;
`else
  localparam int STALL_ACCEPTS = 2;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        in_valid_i;
  logic        in_ready_o;
  uround_res_t urnd_i;
  roundmode_e  rnd_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;

  fp_round_stage dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .urnd_i      (urnd_i),
    .rnd_i       (rnd_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .fflags_o    (fflags_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    int          id;
    int          acc;
    int          lat;  // 0 = latency not checked
  } exp_t;

  typedef struct {
    logic [31:0] u;
    logic [1:0]  rs;
    logic        en;
    logic        inv;
    logic [1:0]  ec;
    logic [2:0]  rm;
    logic [31:0] er;
    logic [4:0]  ef;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;
  int   accepts  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic uround_res_t mk(input logic [31:0] u, input logic [1:0] rs,
                                     input logic en, input logic inv, input logic [1:0] ec);
    uround_res_t r;
    r.u_result = fp_t'(u);
    r.rs       = rs;
    r.round_en = en;
    r.invalid  = inv;
    r.exp_cout = ec;
    return r;
  endfunction

  // Called just after a negedge; returns just after a later negedge with
  // the accepted beat already recorded in the scoreboard.
  task automatic send(input int id, input vec_t v, input int lat);
    int waitc = 0;
    in_valid_i = 1'b1;
    urnd_i     = mk(v.u, v.rs, v.en, v.inv, v.ec);
    rnd_i      = roundmode_e'(v.rm);
    while (1) begin
      #4;
      if (in_ready_o) begin
        sb.push_back('{v.er, v.ef, id, cyc, lat});
        accepts++;
        @(negedge clk_i);
        return;
      end
      @(negedge clk_i);
      waitc++;
      if (waitc > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout id=%0d: in_ready_o stayed 0, required 1", id);
        return;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  // Monitor: samples 1ns before each rising edge.
  logic        stall_prev = 1'b0;
  logic [31:0] prev_res;
  logic [4:0]  prev_fl;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #4;
      if (!reset_i) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", 64'(out_valid_o), 64'd1);
          check("hold_result", 64'(result_o), 64'(prev_res));
          check("hold_fflags", 64'(fflags_o), 64'(prev_fl));
        end
        if (out_valid_o && out_ready_i) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got %0h with no transaction outstanding", result_o);
          end else begin
            e = sb.pop_front();
            check($sformatf("vec%0d_result", e.id), 64'(result_o), 64'(e.res));
            check($sformatf("vec%0d_fflags", e.id), 64'(fflags_o), 64'(e.fl));
            if (e.lat != 0) check($sformatf("vec%0d_latency", e.id), 64'(cyc - e.acc), 64'(e.lat));
          end
        end
        stall_prev = out_valid_o & ~out_ready_i;
        prev_res   = result_o;
        prev_fl    = fflags_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    //           u             rs     en    inv   ec     rm      expected     flags
    vecs.push_back('{32'h3F7FFFFF, 2'b10, 1'b1, 1'b0, 2'b00, 3'b000, 32'h3F800000, 5'b00001});
    vecs.push_back('{32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, 3'b000, 32'h3F800000, 5'b00001});
    vecs.push_back('{32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, 3'b000, 32'h3F800002, 5'b00001});
    vecs.push_back('{32'h3F800000, 2'b10, 1'b1, 1'b0, 2'b00, 3'b100, 32'h3F800001, 5'b00001});
    vecs.push_back('{32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b00, 3'b000, 32'h7F800000, 5'b00101});
    vecs.push_back('{32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b10, 3'b001, 32'h7F7FFFFF, 5'b00101});
    vecs.push_back('{32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b00, 3'b001, 32'h7F7FFFFF, 5'b00001});
    vecs.push_back('{32'hFF7FFFFF, 2'b11, 1'b1, 1'b0, 2'b10, 3'b011, 32'hFF7FFFFF, 5'b00101});
    vecs.push_back('{32'hFF7FFFFF, 2'b11, 1'b1, 1'b0, 2'b00, 3'b010, 32'hFF800000, 5'b00101});
    vecs.push_back('{32'h7F7FFFFF, 2'b01, 1'b1, 1'b0, 2'b00, 3'b010, 32'h7F7FFFFF, 5'b00001});
    vecs.push_back('{32'h7F7FFFFF, 2'b01, 1'b1, 1'b0, 2'b00, 3'b011, 32'h7F800000, 5'b00101});
    vecs.push_back('{32'h7FC00000, 2'b11, 1'b0, 1'b1, 2'b00, 3'b000, 32'h7FC00000, 5'b10000});
    vecs.push_back('{32'h007FFFFF, 2'b10, 1'b1, 1'b0, 2'b00, 3'b000, 32'h00800000, 5'b00011});
    vecs.push_back('{32'h00000001, 2'b01, 1'b1, 1'b0, 2'b00, 3'b000, 32'h00000001, 5'b00011});
    vecs.push_back('{32'h00000004, 2'b00, 1'b1, 1'b0, 2'b00, 3'b000, 32'h00000004, 5'b00000});
    vecs.push_back('{32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, 3'b101, 32'h3F800002, 5'b00001});
    vecs.push_back('{32'h3F800001, 2'b10, 1'b1, 1'b0, 2'b00, 3'b001, 32'h3F800001, 5'b00001});
    vecs.push_back('{32'h40000000, 2'b01, 1'b1, 1'b1, 2'b01, 3'b000, 32'h40000000, 5'b10011});
    vecs.push_back('{32'h40000000, 2'b00, 1'b1, 1'b0, 2'b01, 3'b000, 32'h40000000, 5'b00000});
    vecs.push_back('{32'hC0000001, 2'b11, 1'b0, 1'b0, 2'b10, 3'b011, 32'hC0000001, 5'b00000});
    vecs.push_back('{32'h7F7FFFFF, 2'b11, 1'b1, 1'b0, 2'b10, 3'b010, 32'h7F7FFFFF, 5'b00101});
    vecs.push_back('{32'hFF7FFFFF, 2'b10, 1'b1, 1'b0, 2'b00, 3'b100, 32'hFF800000, 5'b00101});

    reset_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    urnd_i      = '0;
    rnd_i       = RNE;
    repeat (2) @(negedge clk_i);
    check("reset_out_valid", 64'(out_valid_o), 64'd0);
    check("reset_in_ready", 64'(in_ready_o), 64'd1);
    check("reset_result", 64'(result_o), 64'd0);
    check("reset_fflags", 64'(fflags_o), 64'd0);
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Directed vectors back to back; the first, into an empty pipe, also
    // checks the two-cycle latency.
    foreach (vecs[i]) send(i, vecs[i], (i == 0) ? 2 : 0);
    in_valid_i = 1'b0;
    drain();

    // Backpressure: four beats offered while the output is stalled.
    @(negedge clk_i);
    out_ready_i = 1'b0;
    accepts     = 0;
    fork
      begin
        for (int k = 0; k < 4; k++)
          send(100 + k, '{32'h40000000 | 32'(k), 2'b00, 1'b1, 1'b0, 2'b00, 3'b000,
                          32'h40000000 | 32'(k), 5'b00000}, 0);
        in_valid_i = 1'b0;
      end
      begin
        repeat (5) @(negedge clk_i);
        #4;
        check("stall_accepts", 64'(accepts), 64'(STALL_ACCEPTS));
        check("stall_in_ready", 64'(in_ready_o), 64'd0);
        @(negedge clk_i);
        out_ready_i = 1'b1;
      end
    join
    drain();

    // Reset with both stages full.
    @(negedge clk_i);
    out_ready_i = 1'b0;
    send(200, vecs[0], 0);
    send(201, vecs[2], 0);
    in_valid_i = 1'b0;
    #2;
    reset_i = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid_o), 64'd0);
    check("midrst_in_ready", 64'(in_ready_o), 64'd1);
    check("midrst_result", 64'(result_o), 64'd0);
    sb.delete();
    @(negedge clk_i);
    reset_i     = 1'b1;
    out_ready_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check("postrst_out_valid", 64'(out_valid_o), 64'd0);

    // One more beat after the reset to confirm the pipe still works.
    send(300, vecs[4], 2);
    in_valid_i = 1'b0;
    drain();
    repeat (2) @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
